picorv32_mem_bridge: RTL

Next-generation bridge between the PicoRV32 native memory bus and the word-addressed memory controller. It replaces pulse-through request generation with a registered transaction FSM. It also adds byte-enable writes, an explicit write acknowledge, address-window checking with error response, and an optional response timeout. It sits between the core and the memory controller, one instance per memory region.

---
 rtl/picorv32_bridge_pkg.sv | 9 +
 rtl/picorv32_bridge_timer.sv | 27 ++
 rtl/picorv32_mem_bridge.sv | 130 +++++++++++++
 3 files changed

// File: rtl/picorv32_bridge_pkg.sv
// Shared types and constants for the PicoRV32 memory bridge and its timeout timer.
package picorv32_bridge_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;
   localparam int          STRB_W           = 4;

endpackage

// File: rtl/picorv32_bridge_timer.sv
// WAIT-state watchdog: cleared by load, counts while enabled, flags the last permitted cycle.
module picorv32_bridge_timer #(
   parameter int LIMIT = 256
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic enable,
   output logic expire
);

   localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (reset)
         count <= '0;
      else if (load)
         count <= '0;
      else if (enable && !expire)
         count <= count + CW'(1);
   end

   assign expire = enable && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/picorv32_mem_bridge.sv
// PicoRV32 native bus to word-addressed memory controller bridge with window check and error response.
// Optional response timeout enabled by defining PICORV32_BRIDGE_TIMEOUT_EN.
module picorv32_mem_bridge
   import picorv32_bridge_pkg::*;
#(
   parameter int          ADDR_WIDTH     = 10,
   parameter int          DATA_WIDTH     = 32,
   parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
   parameter logic [31:0] ERR_DATA       = DEFAULT_ERR_DATA,
   parameter int          TIMEOUT_CYCLES = 256
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  mem_valid,
   input  logic                  mem_instr,
   output logic                  mem_ready,
   input  logic [31:0]           mem_addr,
   input  logic [31:0]           mem_wdata,
   input  logic [STRB_W-1:0]     mem_wstrb,
   output logic [31:0]           mem_rdata,
   output logic                  cpu_wr_req,
   output logic                  cpu_rd_req,
   output logic [ADDR_WIDTH-1:0] cpu_addr,
   output logic [DATA_WIDTH-1:0] cpu_data_in,
   output logic [STRB_W-1:0]     cpu_be,
   input  logic [DATA_WIDTH-1:0] cpu_data_out,
   input  logic                  cpu_data_valid,
   input  logic                  cpu_ack,
   output logic                  bus_error
);

   localparam logic [63:0] WINDOW = 64'd4 << ADDR_WIDTH;

   if (DATA_WIDTH != 32) begin : g_bad_data_width
      $error("picorv32_mem_bridge: DATA_WIDTH must be 32");
   end
   if ((64'(BASE_ADDR) & (WINDOW - 64'd1)) != 64'd0) begin : g_bad_base
      $error("picorv32_mem_bridge: BASE_ADDR must be aligned to the window size");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("picorv32_mem_bridge: TIMEOUT_CYCLES must be at least 1");
   end

   state_t      state;
   logic        is_write;
   logic        instr_unused;   // kept for debug visibility only
   logic [32:0] off;
   logic        in_win;
   logic        tmo_expire;

   // Extra top bit catches addresses below the base (subtraction borrows).
   assign off    = {1'b0, mem_addr} - {1'b0, BASE_ADDR};
   assign in_win = !off[32] && ({31'd0, off} < WINDOW);

`ifdef PICORV32_BRIDGE_TIMEOUT_EN
   picorv32_bridge_timer #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timer (
      .clk    (clk),
      .reset  (reset),
      .load   (state == ISSUE),
      .enable (state == WAIT),
      .expire (tmo_expire)
   );
`else
   assign tmo_expire = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         is_write     <= 1'b0;
         instr_unused <= 1'b0;
         mem_ready    <= 1'b0;
         mem_rdata    <= '0;
         cpu_wr_req   <= 1'b0;
         cpu_rd_req   <= 1'b0;
         cpu_addr     <= '0;
         cpu_data_in  <= '0;
         cpu_be       <= '0;
         bus_error    <= 1'b0;
      end else begin
         cpu_wr_req <= 1'b0;
         cpu_rd_req <= 1'b0;
         mem_ready  <= 1'b0;
         bus_error  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (mem_valid) begin
                  instr_unused <= mem_instr;
                  if (in_win) begin
                     cpu_addr    <= off[ADDR_WIDTH+1:2];
                     cpu_data_in <= mem_wdata;
                     cpu_be      <= mem_wstrb;
                     is_write    <= |mem_wstrb;
                     cpu_wr_req  <= |mem_wstrb;
                     cpu_rd_req  <= ~|mem_wstrb;
                     state       <= ISSUE;
                  end else begin
                     // Out-of-window: answer directly, the controller never sees it.
                     mem_rdata <= ERR_DATA;
                     bus_error <= 1'b1;
                     mem_ready <= 1'b1;
                     state     <= DONE;
                  end
               end
            end
            ISSUE: state <= WAIT;
            WAIT: begin
               if (!is_write && cpu_data_valid) begin
                  mem_rdata <= cpu_data_out;
                  mem_ready <= 1'b1;
                  state     <= DONE;
               end else if (is_write && cpu_ack) begin
                  mem_rdata <= '0;
                  mem_ready <= 1'b1;
                  state     <= DONE;
               end else if (tmo_expire) begin
                  mem_rdata <= is_write ? 32'd0 : ERR_DATA;
                  bus_error <= 1'b1;
                  mem_ready <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: state <= IDLE;
         endcase
      end
   end

endmodule
